vga_pattern_gen: RTL and testbench

Parametrised hardware test-pattern generator for VGA monitors. It is the successor to the fixed three-band horizontal test. It has its own timing generator, driven by a pixel clock-enable on the single system clock, so no divided clock buffer is needed. It provides four run-time-selectable patterns with a configurable band count and colour depth. Mode changes are handshaked and take effect only at frame boundaries, so a frame never tears.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing_gen.sv | 65 ++++++
 rtl/vga_pattern_gen.sv | 239 +++++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator:
// mode encodings, band palette, 640x480@60 timing defaults and a total-count helper.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_HBARS    = 2'd0,
        MODE_VBARS    = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_GRADIENT = 2'd3
    } mode_e;

    // RGB masks indexed by band mod 7: R, G, B, Y, C, M, W.
    // Entry 7 is never selected and is only there to keep the table a power of two.
    localparam logic [7:0][2:0] PALETTE = {
        3'b000, 3'b111, 3'b101, 3'b011,
        3'b110, 3'b001, 3'b010, 3'b100
    };

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int vga_total(int act, int fp, int syn, int bp);
        return act + fp + syn + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters advancing on pix_ce, sync decode, de,
// pixel coordinates, end-of-line/frame flags and a frame_start pulse.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int H_W     = $clog2(H_TOTAL),
    localparam int V_W     = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_ce,
    output logic [H_W-1:0] x,
    output logic [V_W-1:0] y,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic           h_last,
    output logic           v_last,
    output logic           frame_start
);

    logic hs_on;
    logic vs_on;

    always_ff @(posedge clk) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                x <= '0;
                y <= v_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign h_last = (int'(x) == H_TOTAL - 1);
    assign v_last = (int'(y) == V_TOTAL - 1);

    assign hs_on = (int'(x) >= H_ACTIVE + H_FP) &&
                   (int'(x) <  H_ACTIVE + H_FP + H_SYNC);
    assign vs_on = (int'(y) >= V_ACTIVE + V_FP) &&
                   (int'(y) <  V_ACTIVE + V_FP + V_SYNC);

    assign hsync = hs_on ? SYNC_POL : ~SYNC_POL;
    assign vsync = vs_on ? SYNC_POL : ~SYNC_POL;
    assign de    = (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);

    // Gated by rst so no pulse is seen while the block is held in reset.
    assign frame_start = rst && pix_ce && (x == '0) && (y == '0);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: four frame-synchronous selectable patterns
// (HBARS, VBARS, CHECKER, GRADIENT) with mode_req/mode_ack handshake.
// Ports: clk, rst (sync, active-low), pix_ce, mode_req/mode_in -> mode_ack,
// active_mode, frame_start, VGA_HS/VGA_VS, VGA_R/G/B (COLOR_W bits each).
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int COLOR_W   = 4,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit SYNC_POL  = 1'b0,
    parameter int N_BANDS   = 3,
    parameter int CELL_LOG2 = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_ce,
    input  logic               mode_req,
    input  logic [1:0]         mode_in,
    output logic               mode_ack,
    output logic [1:0]         active_mode,
    output logic               frame_start,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int BAND_H  = V_ACTIVE / N_BANDS;
    localparam int BAND_W  = H_ACTIVE / N_BANDS;
    localparam int STEP    = H_ACTIVE >> COLOR_W;

    if (N_BANDS < 1 || N_BANDS > 16) begin : g_bad_bands
        $error("N_BANDS must be in 1..16");
    end
    if (STEP < 1) begin : g_bad_step
        $error("H_ACTIVE >> COLOR_W must be at least 1");
    end

    logic [H_W-1:0] x;
    logic [V_W-1:0] y;
    logic           hsync;
    logic           vsync;
    logic           de;
    logic           h_last;
    logic           v_last;
    logic           unused_xy;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .x           (x),
        .y           (y),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .h_last      (h_last),
        .v_last      (v_last),
        .frame_start (frame_start)
    );

    // Only one bit of each coordinate feeds the checker.
    assign unused_xy = ^{x, y};

    // Mode handshake
    logic       pending;
    logic [1:0] pending_mode;
    logic [1:0] act_q;
    logic       apply;
    logic [1:0] mode_eff;

    assign apply       = frame_start && pending;
    assign mode_ack    = apply;
    assign active_mode = act_q;
    // Pixel (0,0) of a new frame is coloured in the same cycle the mode is
    // applied, so it must already see the new mode.
    assign mode_eff    = apply ? pending_mode : act_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending      <= 1'b0;
            pending_mode <= 2'd0;
            act_q        <= 2'd0;
        end else begin
            if (apply) begin
                act_q   <= pending_mode;
                pending <= 1'b0;
            end
            // A request on the apply cycle re-arms for the next frame.
            if (mode_req) begin
                pending      <= 1'b1;
                pending_mode <= mode_in;
            end
        end
    end

    // Band / step trackers describing the pixel at the current x, y
    logic [V_W-1:0]     row_cnt;
    logic [3:0]         row_band;
    logic [2:0]         row_pal;
    logic [H_W-1:0]     col_cnt;
    logic [3:0]         col_band;
    logic [2:0]         col_pal;
    logic [H_W-1:0]     step_cnt;
    logic [COLOR_W-1:0] level;

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_cnt  <= '0;
            row_band <= '0;
            row_pal  <= '0;
        end else if (pix_ce && h_last) begin
            if (v_last) begin
                row_cnt  <= '0;
                row_band <= '0;
                row_pal  <= '0;
            end else if (int'(row_cnt) == BAND_H - 1 &&
                         int'(row_band) != N_BANDS - 1) begin
                row_cnt  <= '0;
                row_band <= row_band + 1'b1;
                row_pal  <= (row_pal == 3'd6) ? 3'd0 : row_pal + 1'b1;
            end else begin
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_cnt  <= '0;
            col_band <= '0;
            col_pal  <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                col_cnt  <= '0;
                col_band <= '0;
                col_pal  <= '0;
            end else if (int'(col_cnt) == BAND_W - 1 &&
                         int'(col_band) != N_BANDS - 1) begin
                col_cnt  <= '0;
                col_band <= col_band + 1'b1;
                col_pal  <= (col_pal == 3'd6) ? 3'd0 : col_pal + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            step_cnt <= '0;
            level    <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                step_cnt <= '0;
                level    <= '0;
            end else if (int'(step_cnt) == STEP - 1) begin
                step_cnt <= '0;
                if (level != {COLOR_W{1'b1}}) begin
                    level <= level + 1'b1;
                end
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    // Colour selection
    logic [2:0]         mask;
    logic [COLOR_W-1:0] r_n;
    logic [COLOR_W-1:0] g_n;
    logic [COLOR_W-1:0] b_n;

    always_comb begin
        mask = 3'b000;
        r_n  = '0;
        g_n  = '0;
        b_n  = '0;
        unique case (mode_e'(mode_eff))
            MODE_HBARS:    mask = PALETTE[row_pal];
            MODE_VBARS:    mask = PALETTE[col_pal];
            MODE_CHECKER:  mask = {3{x[CELL_LOG2] ^ y[CELL_LOG2]}};
            MODE_GRADIENT: begin
                r_n = level;
                g_n = level;
                b_n = level;
            end
            default:       mask = 3'b000;
        endcase
        r_n = r_n | {COLOR_W{mask[2]}};
        g_n = g_n | {COLOR_W{mask[1]}};
        b_n = b_n | {COLOR_W{mask[0]}};
        if (!de) begin
            r_n = '0;
            g_n = '0;
            b_n = '0;
        end
    end

    // Output stage keeps sync and colour aligned one pixel behind the counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            VGA_HS <= ~SYNC_POL;
            VGA_VS <= ~SYNC_POL;
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
        end else if (pix_ce) begin
            VGA_HS <= hsync;
            VGA_VS <= vsync;
            VGA_R  <= r_n;
            VGA_G  <= g_n;
            VGA_B  <= b_n;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen on a reduced raster (44x24 totals)
// using a reference pixel model and a scoreboard queue.
module tb_vga_pattern_gen;

    localparam int HA = 36, HF = 2, HS = 4, HB = 2;
    localparam int VA = 20, VF = 1, VS = 2, VB = 1;
    localparam int CW = 4, NB = 8, CL = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic          clk;
    logic          rst;
    logic          pix_ce;
    logic          mode_req;
    logic [1:0]    mode_in;
    logic          mode_ack;
    logic [1:0]    active_mode;
    logic          frame_start;
    logic          VGA_HS;
    logic          VGA_VS;
    logic [CW-1:0] VGA_R;
    logic [CW-1:0] VGA_G;
    logic [CW-1:0] VGA_B;

    vga_pattern_gen #(
        .COLOR_W (CW),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0),
        .N_BANDS (NB),
        .CELL_LOG2(CL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .mode_req    (mode_req),
        .mode_in     (mode_in),
        .mode_ack    (mode_ack),
        .active_mode (active_mode),
        .frame_start (frame_start),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] pix;
        logic        fs;
        logic        ack;
        logic [1:0]  mode;
        int          h;
        int          v;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_err = 0;

    // Reference state
    int          mh, mv;
    logic [1:0]  m_act, m_pmode;
    logic        m_pend;
    logic [13:0] m_out;
    logic        obs_fs, obs_ack;

    function automatic logic [2:0] pal(int idx);
        case (idx)
            0: return 3'b100;
            1: return 3'b010;
            2: return 3'b001;
            3: return 3'b110;
            4: return 3'b011;
            5: return 3'b101;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [13:0] model_pix(int h, int v, logic [1:0] m);
        logic hs, vs;
        logic [CW-1:0] r, g, b;
        logic [2:0] c;
        int band, lvl;
        hs = !(h >= HA + HF && h < HA + HF + HS);
        vs = !(v >= VA + VF && v < VA + VF + VS);
        r = '0; g = '0; b = '0; c = 3'b000;
        if (h < HA && v < VA) begin
            case (m)
                2'd0: begin
                    band = v / (VA / NB);
                    if (band > NB - 1) band = NB - 1;
                    c = pal(band % 7);
                end
                2'd1: begin
                    band = h / (HA / NB);
                    if (band > NB - 1) band = NB - 1;
                    c = pal(band % 7);
                end
                2'd2: c = (((h >> CL) ^ (v >> CL)) & 1) != 0 ? 3'b111 : 3'b000;
                default: begin
                    lvl = h / (HA >> CW);
                    if (lvl > (1 << CW) - 1) lvl = (1 << CW) - 1;
                    r = CW'(lvl); g = CW'(lvl); b = CW'(lvl);
                end
            endcase
            if (c[2]) r = '1;
            if (c[1]) g = '1;
            if (c[0]) b = '1;
        end
        return {hs, vs, r, g, b};
    endfunction

    // Drive one clk of stimulus, update the reference and queue the expectation.
    task automatic tick(input logic ce, input logic req,
                        input logic [1:0] mi, input logic rs);
        exp_t e;
        pix_ce = ce; mode_req = req; mode_in = mi; rst = rs;
        #3;
        obs_fs = frame_start;
        obs_ack = mode_ack;
        e.fs = 1'b0; e.ack = 1'b0; e.h = mh; e.v = mv;
        if (!rs) begin
            mh = 0; mv = 0; m_act = 2'd0; m_pend = 1'b0; m_pmode = 2'd0;
            m_out = {1'b1, 1'b1, {(3*CW){1'b0}}};
        end else begin
            if (ce && mh == 0 && mv == 0) begin
                e.fs = 1'b1;
                if (m_pend) begin
                    e.ack = 1'b1; m_act = m_pmode; m_pend = 1'b0;
                end
            end
            if (req) begin
                m_pend = 1'b1; m_pmode = mi;
            end
            if (ce) begin
                m_out = model_pix(mh, mv, m_act);
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end else begin
                    mh++;
                end
            end
        end
        e.pix = m_out; e.mode = m_act;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 2'd3, 1'b0);
            e = sb.pop_front();
            n_checks++;
            if ({VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B} !== e.pix || active_mode !== e.mode) begin
                n_err++;
                $display("FAIL reset_out got %h/%0d exp %h/%0d",
                         {VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}, active_mode, e.pix, e.mode);
            end
            n_checks++;
            if ({obs_fs, obs_ack} !== {e.fs, e.ack}) begin
                n_err++;
                $display("FAIL reset_pulse got fs=%b ack=%b exp fs=%b ack=%b",
                         obs_fs, obs_ack, e.fs, e.ack);
            end
        end
    endtask

    task automatic test_timing();
        exp_t e;
        int hs_lo = 0, vs_lo = 0, fs_n = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick(i % 4 == 0, 1'b0, 2'd0, 1'b1);
            e = sb.pop_front();
            n_checks++;
            if ({VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B} !== e.pix || active_mode !== e.mode) begin
                n_err++;
                $display("FAIL hbars_pix h=%0d v=%0d got %h/%0d exp %h/%0d", e.h, e.v,
                         {VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}, active_mode, e.pix, e.mode);
            end
            n_checks++;
            if ({obs_fs, obs_ack} !== {e.fs, e.ack}) begin
                n_err++;
                $display("FAIL hbars_pulse h=%0d v=%0d got %b%b exp %b%b",
                         e.h, e.v, obs_fs, obs_ack, e.fs, e.ack);
            end
            if (i % 4 == 0) begin
                if (!VGA_HS) hs_lo++;
                if (!VGA_VS) vs_lo++;
            end
            if (obs_fs) fs_n++;
        end
        n_checks++;
        if (hs_lo != HS * VT) begin
            n_err++;
            $display("FAIL hs_count got %0d exp %0d", hs_lo, HS * VT);
        end
        n_checks++;
        if (vs_lo != VS * HT) begin
            n_err++;
            $display("FAIL vs_count got %0d exp %0d", vs_lo, VS * HT);
        end
        n_checks++;
        if (fs_n != 1) begin
            n_err++;
            $display("FAIL frame_start_count got %0d exp 1", fs_n);
        end
    endtask

    // Request a mode mid-frame, then run the rest of that frame and one full frame.
    task automatic test_pattern(input logic [1:0] m, input string name);
        exp_t e;
        int nce = 0, acks = 0;
        logic ce;
        for (int i = 0; i < 20 * FRAME && nce < 2 * FRAME; i++) begin
            ce = ($urandom_range(0, 2) == 0);
            tick(ce, i == 600, m, 1'b1);
            if (ce) nce++;
            e = sb.pop_front();
            n_checks++;
            if ({VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B} !== e.pix || active_mode !== e.mode) begin
                n_err++;
                $display("FAIL %s_pix h=%0d v=%0d got %h/%0d exp %h/%0d", name, e.h, e.v,
                         {VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}, active_mode, e.pix, e.mode);
            end
            n_checks++;
            if ({obs_fs, obs_ack} !== {e.fs, e.ack}) begin
                n_err++;
                $display("FAIL %s_pulse h=%0d v=%0d got %b%b exp %b%b",
                         name, e.h, e.v, obs_fs, obs_ack, e.fs, e.ack);
            end
            if (obs_ack) acks++;
        end
        n_checks++;
        if (nce != 2 * FRAME) begin
            n_err++;
            $display("FAIL %s_budget got %0d pixels exp %0d", name, nce, 2 * FRAME);
        end
        n_checks++;
        if (acks != 1 || active_mode !== m) begin
            n_err++;
            $display("FAIL %s_ack got acks=%0d mode=%0d exp acks=1 mode=%0d",
                     name, acks, active_mode, m);
        end
    endtask

    // Last request wins; a request on the frame-start cycle waits a frame.
    task automatic test_mode_handshake();
        exp_t e;
        int acks = 0;
        logic req;
        logic [1:0] mi;
        for (int i = 0; i < 6 * FRAME; i++) begin
            req = 1'b0; mi = 2'd0;
            if (i == 100)       begin req = 1'b1; mi = 2'd2; end
            if (i == 400)       begin req = 1'b1; mi = 2'd1; end
            if (i == 2 * FRAME) begin req = 1'b1; mi = 2'd3; end
            tick(i % 2 == 0, req, mi, 1'b1);
            e = sb.pop_front();
            n_checks++;
            if ({VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B} !== e.pix || active_mode !== e.mode) begin
                n_err++;
                $display("FAIL hs_pix h=%0d v=%0d got %h/%0d exp %h/%0d", e.h, e.v,
                         {VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}, active_mode, e.pix, e.mode);
            end
            n_checks++;
            if ({obs_fs, obs_ack} !== {e.fs, e.ack}) begin
                n_err++;
                $display("FAIL hs_pulse i=%0d got %b%b exp %b%b",
                         i, obs_fs, obs_ack, e.fs, e.ack);
            end
            if (i == 2 * FRAME + 1) begin
                n_checks++;
                if (active_mode !== 2'd1) begin
                    n_err++;
                    $display("FAIL last_req_wins got %0d exp 1", active_mode);
                end
            end
            if (obs_ack) acks++;
        end
        n_checks++;
        if (acks != 2 || active_mode !== 2'd3) begin
            n_err++;
            $display("FAIL hs_acks got %0d mode=%0d exp 2 mode=3", acks, active_mode);
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        int fs_n = 0;
        for (int i = 0; i < 4 * FRAME && !(mv == 10 && mh == 40); i++) begin
            tick(i % 2 == 0, 1'b0, 2'd0, 1'b1);
            void'(sb.pop_front());
        end
        n_checks++;
        if (VGA_HS !== 1'b0) begin
            n_err++;
            $display("FAIL pre_reset_hs got %b exp 0", VGA_HS);
        end
        for (int i = 0; i < 2 + 2 * FRAME; i++) begin
            tick(i != 1 && (i % 2 == 0 || i == 0), 1'b0, 2'd0, i != 0);
            e = sb.pop_front();
            n_checks++;
            if ({VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B} !== e.pix || active_mode !== e.mode) begin
                n_err++;
                $display("FAIL rst_mid_pix h=%0d v=%0d got %h/%0d exp %h/%0d", e.h, e.v,
                         {VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}, active_mode, e.pix, e.mode);
            end
            n_checks++;
            if ({obs_fs, obs_ack} !== {e.fs, e.ack}) begin
                n_err++;
                $display("FAIL rst_mid_pulse i=%0d got %b%b exp %b%b",
                         i, obs_fs, obs_ack, e.fs, e.ack);
            end
            if (obs_fs) fs_n++;
            if (i == 2) begin
                n_checks++;
                if (!obs_fs) begin
                    n_err++;
                    $display("FAIL restart_fs got %b exp 1", obs_fs);
                end
            end
        end
        n_checks++;
        if (fs_n != 1 || active_mode !== 2'd0) begin
            n_err++;
            $display("FAIL rst_mid_frame got fs=%0d mode=%0d exp fs=1 mode=0",
                     fs_n, active_mode);
        end
    endtask

    initial begin
        rst = 1'b0; pix_ce = 1'b0; mode_req = 1'b0; mode_in = 2'd0;
        mh = 0; mv = 0; m_act = 2'd0; m_pmode = 2'd0; m_pend = 1'b0;
        m_out = '0; obs_fs = 1'b0; obs_ack = 1'b0;
        test_reset();
        test_timing();
        test_pattern(2'd1, "vbars");
        test_pattern(2'd2, "checker");
        test_pattern(2'd3, "gradient");
        test_mode_handshake();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
